// File: rtl/pattern_select_ctrl_if.sv
// Board-facing signal bundle of the LED pattern selector: raw keys and
// switch in, registered pattern select and change strobe out.
interface pattern_select_ctrl_if;
    logic       key_next_n;
    logic       key_prev_n;
    logic       auto_en;
    logic [2:0] sel;
    logic       sel_changed;

    modport master (
        output key_next_n, key_prev_n, auto_en,
        input  sel, sel_changed
    );

    modport slave (
        input  key_next_n, key_prev_n, auto_en,
        output sel, sel_changed
    );
endinterface

// File: rtl/pattern_select_ctrl.sv
// Conditions the two board push-buttons (synchronize, debounce, press-edge)
// and steps a wrapping pattern select, with an optional timed auto-cycle.
module pattern_select_ctrl #(
    parameter int NUM_PATTERNS    = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_CYCLES    = 100000000
) (
    input  logic                    clk,
    input  logic                    rst,
    pattern_select_ctrl_if.slave    bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]      SEL_LAST = 3'(NUM_PATTERNS - 1);

    // Bit 0 carries the "next" key, bit 1 the "prev" key; 1 means released.
    logic [1:0]      key_raw;
    logic [1:0]      key_meta_q, key_sync_q;
    logic [1:0]      db_q, db_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic            auto_meta_q, auto_sync_q;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [2:0]      sel_q, sel_d;
    logic            changed_q;
    logic            next_ev, prev_ev, auto_tick;

    assign key_raw = {bus.key_prev_n, bus.key_next_n};

    function automatic logic [2:0] sel_inc(input logic [2:0] s);
        return (s == SEL_LAST) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] sel_dec(input logic [2:0] s);
        return (s == 3'd0) ? SEL_LAST : s - 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q  <= 2'b11;
            key_sync_q  <= 2'b11;
            db_q        <= 2'b11;
            db_prev_q   <= 2'b11;
            auto_meta_q <= 1'b0;
            auto_sync_q <= 1'b0;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
        end else begin
            key_meta_q  <= key_raw;
            key_sync_q  <= key_meta_q;
            db_prev_q   <= db_q;
            auto_meta_q <= bus.auto_en;
            auto_sync_q <= auto_meta_q;
            // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
            for (int k = 0; k < 2; k++) begin
                if (key_sync_q[k] == db_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    db_q[k]     <= key_sync_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    assign next_ev   = db_prev_q[0] & ~db_q[0];
    assign prev_ev   = db_prev_q[1] & ~db_q[1];
    assign auto_tick = auto_sync_q && (dwell_q == DW_LAST);

    always_comb begin
        sel_d   = sel_q;
        dwell_d = dwell_q;
        if (!auto_sync_q || auto_tick) dwell_d = '0;
        else                           dwell_d = dwell_q + DW_W'(1);
        // Manual events win over a coincident tick and restart the dwell period.
        if (next_ev && prev_ev) begin
            dwell_d = '0;
        end else if (next_ev) begin
            sel_d   = sel_inc(sel_q);
            dwell_d = '0;
        end else if (prev_ev) begin
            sel_d   = sel_dec(sel_q);
            dwell_d = '0;
        end else if (auto_tick) begin
            sel_d   = sel_inc(sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= 3'd0;
            changed_q <= 1'b0;
            dwell_q   <= '0;
        end else begin
            sel_q     <= sel_d;
            changed_q <= (sel_d != sel_q);
            dwell_q   <= dwell_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sel_changed = changed_q;

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// Bench for pattern_select_ctrl: directed timing scenarios plus random key,
// switch and reset traffic, all checked every cycle against a behavioural model.
module tb_pattern_select_ctrl;

    localparam int NP    = 5;
    localparam int DEB   = 4;
    localparam int DWELL = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   pulses;

    pattern_select_ctrl_if bus ();

    pattern_select_ctrl #(
        .NUM_PATTERNS    (NP),
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from the rules directly: a key level is taken once it has differed
    // from the accepted level for DEB samples in a row, a press takes effect one
    // edge after acceptance, and selection arithmetic is done modulo NP.
    int         m_sel, m_run[2], m_dwell, m_nsel;
    bit         m_changed, m_tick;
    bit         m_s1[2], m_s2[2], m_db[2], m_pend[2], m_a1, m_a2, m_raw[2];
    logic [3:0] exp_q[$];
    logic [3:0] exp_e;

    always @(posedge clk) begin
        m_raw[0] = bus.key_next_n;
        m_raw[1] = bus.key_prev_n;
        if (rst) begin
            m_sel = 0; m_changed = 0; m_dwell = 0; m_a1 = 0; m_a2 = 0;
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1; m_s2[k] = 1; m_db[k] = 1; m_pend[k] = 0; m_run[k] = 0;
            end
        end else begin
            m_tick = m_a2 && (m_dwell == DWELL - 1);
            m_nsel = m_sel;
            if (m_pend[0] && m_pend[1]) begin
                m_dwell = 0;
            end else if (m_pend[0]) begin
                m_nsel = (m_sel + 1) % NP;
                m_dwell = 0;
            end else if (m_pend[1]) begin
                m_nsel = (m_sel + NP - 1) % NP;
                m_dwell = 0;
            end else begin
                m_dwell = m_a2 ? (m_dwell + 1) % DWELL : 0;
                if (m_tick) m_nsel = (m_sel + 1) % NP;
            end
            m_changed = (m_nsel != m_sel);
            m_sel = m_nsel;
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 0;
                if (m_s2[k] != m_db[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_db[k]   = m_s2[k];
                        m_run[k]  = 0;
                        m_pend[k] = !m_db[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = m_raw[k];
            end
            m_a2 = m_a1;
            m_a1 = bus.auto_en;
        end
        exp_q.push_back({m_changed, 3'(m_sel)});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("model_sel", bus.sel, exp_e[2:0]);
            check("model_sel_changed", bus.sel_changed, exp_e[3]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.sel_changed) pulses++;
        end
    endtask

    // which: 0 = next, 1 = prev, 2 = both
    task automatic press(input int which, input int hold);
        if (which != 1) bus.key_next_n = 1'b0;
        if (which != 0) bus.key_prev_n = 1'b0;
        cycles(hold);
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;
        cycles(8);
    endtask

    int exp_edges[7] = '{12, 22, 32, 42, 52, 62, 72};
    int exp_sels[7]  = '{1, 2, 3, 4, 0, 1, 2};
    int pe_q[$];
    int ps_q[$];
    int hold;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        rst      = 1'b1;
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;
        bus.auto_en    = 1'b0;

        // Single press: update lands on edge DEB+3 = 7, release is silent.
        do_reset(3);
        check("rst_sel", bus.sel, 0);
        check("rst_sel_changed", bus.sel_changed, 0);
        bus.key_next_n = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.sel_changed) pulses++;
            if (k == 6) check("s1_sel_edge6", bus.sel, 0);
            if (k == 7) check("s1_sel_edge7", bus.sel, 1);
            if (k == 7) check("s1_chg_edge7", bus.sel_changed, 1);
            if (k == 8) check("s1_chg_edge8", bus.sel_changed, 0);
        end
        check("s1_pulses", pulses, 1);
        bus.key_next_n = 1'b1;
        pulses = 0;
        cycles(12);
        check("s1_release_pulses", pulses, 0);
        check("s1_release_sel", bus.sel, 1);

        // Wrap in both directions.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            press(0, 10);
            check("s2_next_sel", bus.sel, (i + 1) % NP);
        end
        press(1, 10);
        check("s2_prev_wrap", bus.sel, NP - 1);

        // Glitch and bounce, then a final settle low: one increment (4 -> 0).
        pulses = 0;
        bus.key_next_n = 1'b0; cycles(3);
        bus.key_next_n = 1'b1; cycles(3);
        for (int i = 0; i < 3; i++) begin
            bus.key_next_n = 1'b0; cycles(2);
            bus.key_next_n = 1'b1; cycles(2);
        end
        check("s3_bounce_pulses", pulses, 0);
        bus.key_next_n = 1'b0;
        for (int k = 1; k <= DEB + 3; k++) begin
            @(negedge clk);
            if (bus.sel_changed) pulses++;
            if (k == DEB + 2) check("s3_sel_before", bus.sel, NP - 1);
            if (k == DEB + 3) check("s3_sel_after", bus.sel, 0);
        end
        bus.key_next_n = 1'b1;
        cycles(10);
        check("s3_pulses", pulses, 1);

        // Both keys together cancel.
        pulses = 0;
        press(2, 10);
        check("s4_pulses", pulses, 0);
        check("s4_sel", bus.sel, 0);

        // Auto-cycle from reset, then a manual press landing on a tick edge.
        rst = 1'b1;
        bus.auto_en = 1'b1;
        cycles(3);
        rst = 1'b0;
        pe_q.delete();
        ps_q.delete();
        for (int e = 1; e <= 75; e++) begin
            @(negedge clk);
            if (bus.sel_changed) begin
                pe_q.push_back(e);
                ps_q.push_back(int'(bus.sel));
            end
            if (e == 55) bus.key_next_n = 1'b0;
            if (e == 66) bus.key_next_n = 1'b1;
        end
        check("s5_npulses", pe_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < pe_q.size()) begin
                check("s5_pulse_edge", pe_q[i], exp_edges[i]);
                check("s5_pulse_sel", ps_q[i], exp_sels[i]);
            end
        end
        bus.auto_en = 1'b0;
        cycles(12);

        // Reset mid-debounce discards the partial count.
        bus.key_next_n = 1'b0;
        cycles(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s6_rst_sel", bus.sel, 0);
        check("s6_rst_chg", bus.sel_changed, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == DEB + 2) check("s6_sel_before", bus.sel, 0);
            if (k == DEB + 3) check("s6_sel_after", bus.sel, 1);
        end
        bus.key_next_n = 1'b1;
        cycles(10);

        // Random keys, switch and occasional reset, model-checked every cycle.
        for (int seg = 0; seg < 250; seg++) begin
            bus.key_next_n = 1'($urandom_range(0, 1));
            bus.key_prev_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) == 0) bus.auto_en = ~bus.auto_en;
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            cycles(hold);
        end
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
